// File: rtl/btn_dir_ctrl.sv
// Four-button direction controller: synchronize, debounce and edge-detect each button,
// then latch a priority-encoded one-hot direction and emit rate-limited step strobes.
module btn_dir_ctrl #(
    parameter int DEB_COUNT = 500000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       tick,
    input  logic       freeze,
    output logic [3:0] dir,
    output logic [3:0] press_pulse,
    output logic       move_stb
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       raw_s;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       db_q, db_d;
    logic [3:0]       db_prev_q, db_prev_d;
    logic [3:0]       press_q, press_d;
    logic [3:0]       dir_q, dir_d;
    logic             stb_q, stb_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    assign raw_s = {btn_up, btn_down, btn_left, btn_right};

    // Synchronizer, per-button debounce counters and rising-edge press detect
    always_comb begin
        sync1_d   = raw_s;
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        press_d   = db_q & ~db_prev_q;
        for (int i = 0; i < 4; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] >= CNT_MAX) begin
                // >= rather than == so the counter can never run past the limit
                db_d[i]  = sync2_q[i];
                cnt_d[i] = CNT_ZERO;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Direction latch (up > down > left > right) and step strobe using the pre-update direction
    always_comb begin
        dir_d = dir_q;
        stb_d = tick & ~freeze & (dir_q != 4'b0000);
        if (!freeze && (press_q != 4'b0000)) begin
            if (press_q[3]) begin
                dir_d = 4'b1000;
            end else if (press_q[2]) begin
                dir_d = 4'b0100;
            end else if (press_q[1]) begin
                dir_d = 4'b0010;
            end else begin
                dir_d = 4'b0001;
            end
        end else begin
            dir_d = dir_q;
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            db_q      <= 4'b0000;
            db_prev_q <= 4'b0000;
            press_q   <= 4'b0000;
            dir_q     <= 4'b0000;
            stb_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            press_q   <= press_d;
            dir_q     <= dir_d;
            stb_q     <= stb_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dir         = dir_q;
    assign press_pulse = press_q;
    assign move_stb    = stb_q;

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Directed bench for btn_dir_ctrl with DEB_COUNT=4: raw edge to press_pulse is 7 clock edges.
module tb_btn_dir_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       tick, freeze;
    logic [3:0] dir, press_pulse;
    logic       move_stb;

    int n_cmp = 0;
    int n_err = 0;

    btn_dir_ctrl #(.DEB_COUNT(4), .CNT_W(20)) dut (
        .clk         (clk),
        .clr         (clr),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .tick        (tick),
        .freeze      (freeze),
        .dir         (dir),
        .press_pulse (press_pulse),
        .move_stb    (move_stb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    // Held press: six quiet edges, pulse on the seventh, direction on the eighth
    task automatic press_seq(input string tag, input logic [3:0] exp_pp, input logic [3:0] exp_dir);
        for (int i = 0; i < 6; i++) begin
            step();
            chk({tag, "_early"}, press_pulse, 4'b0000);
        end
        step();
        chk({tag, "_pulse"}, press_pulse, exp_pp);
        step();
        chk({tag, "_pulse_end"}, press_pulse, 4'b0000);
        chk({tag, "_dir"}, dir, exp_dir);
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_nopulse"}, press_pulse, 4'b0000);
        end
    endtask

    initial begin
        clr = 1'b0; tick = 1'b0; freeze = 1'b0;
        set_btn(4'b1111);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_dir", dir, 4'b0000);
            chk("rst_pp", press_pulse, 4'b0000);
            chk("rst_stb", {3'b000, move_stb}, 4'b0000);
        end

        // Release clr with up held; tick while stopped must not strobe
        clr = 1'b1;
        set_btn(4'b1000);
        for (int i = 0; i < 6; i++) begin
            tick = (i == 2) ? 1'b1 : 1'b0;
            step();
            chk("up_early", press_pulse, 4'b0000);
            chk("stopped_stb", {3'b000, move_stb}, 4'b0000);
        end
        tick = 1'b0;
        step();
        chk("up_pulse", press_pulse, 4'b1000);
        tick = 1'b1;
        step();
        chk("up_dir", dir, 4'b1000);
        chk("tick_old_dir_stb", {3'b000, move_stb}, 4'b0000);
        chk("up_pulse_end", press_pulse, 4'b0000);
        tick = 1'b0;
        step();
        chk("stb_idle", {3'b000, move_stb}, 4'b0000);
        tick = 1'b1;
        step();
        chk("stb_up", {3'b000, move_stb}, 4'b0001);
        tick = 1'b0;

        set_btn(4'b0000);
        quiet("up_release", 10);
        chk("up_hold_dir", dir, 4'b1000);

        // Three-cycle glitch on left is rejected
        set_btn(4'b0010);
        step(); step(); step();
        set_btn(4'b0000);
        quiet("glitch", 12);
        chk("glitch_dir", dir, 4'b1000);

        set_btn(4'b0010);
        press_seq("left", 4'b0010, 4'b0010);
        set_btn(4'b0000);
        quiet("left_release", 8);

        // Simultaneous up and right: both pulse, up wins
        set_btn(4'b1001);
        press_seq("upright", 4'b1001, 4'b1000);
        set_btn(4'b0000);
        quiet("upright_release", 8);

        set_btn(4'b0100);
        press_seq("down", 4'b0100, 4'b0100);
        set_btn(4'b0000);
        quiet("down_release", 8);

        // Frozen: pulse still emitted, direction held, no strobe, nothing queued
        freeze = 1'b1;
        set_btn(4'b0001);
        press_seq("frz_right", 4'b0001, 4'b0100);
        tick = 1'b1;
        step();
        chk("frz_stb", {3'b000, move_stb}, 4'b0000);
        tick = 1'b0;
        set_btn(4'b0000);
        freeze = 1'b0;
        quiet("frz_release", 8);
        chk("frz_not_queued", dir, 4'b0100);

        set_btn(4'b0001);
        press_seq("right", 4'b0001, 4'b0001);
        set_btn(4'b0000);
        quiet("right_release", 8);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            chk("stb_right_on", {3'b000, move_stb}, 4'b0001);
            tick = 1'b0;
            step();
            chk("stb_right_off", {3'b000, move_stb}, 4'b0000);
        end

        // clr mid-debounce discards the count; full latency needed afterwards
        set_btn(4'b0010);
        step(); step(); step(); step();
        clr = 1'b0;
        step();
        chk("clr_mid_dir", dir, 4'b0000);
        chk("clr_mid_pp", press_pulse, 4'b0000);
        clr = 1'b1;
        press_seq("post_clr_left", 4'b0010, 4'b0010);
        set_btn(4'b0000);
        quiet("post_clr_release", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
